// File: rtl/ecc_smul_ctrl_pkg.sv
// Shared constants for the scalar-multiplication sequencer: widths, command and mode encodings.
package ecc_smul_ctrl_pkg;

    localparam int unsigned MAX_BITS = 256;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned WIDTH_W  = 9;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DBL  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    localparam logic [1:0] MODE_32  = 2'b00;
    localparam logic [1:0] MODE_64  = 2'b01;
    localparam logic [1:0] MODE_128 = 2'b10;
    localparam logic [1:0] MODE_256 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Operand width in bits for a mode code: 32 << mode.
    function automatic logic [WIDTH_W-1:0] width_of(input logic [1:0] mode);
        return WIDTH_W'(32) << mode;
    endfunction

endpackage

// File: rtl/ecc_smul_ctrl.sv
// Left-to-right double-and-add sequencer driving a shared point-arithmetic unit.
module ecc_smul_ctrl #(
    parameter int unsigned MAX_BITS = ecc_smul_ctrl_pkg::MAX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_m,
    output logic                o_busy,
    output logic                o_op_valid,
    output logic [1:0]          o_op,
    input  logic                i_op_ready,
    input  logic                i_op_done,
    output logic                o_done,
    output logic                o_inf,
    output logic [9:0]          o_op_cnt
);
    import ecc_smul_ctrl_pkg::*;

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] m_q, m_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [1:0]          op_q, op_d;
    logic                done_q, done_d;
    logic                inf_q, inf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                bit_c;

    assign bit_c = m_q[idx_q];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= 2'b00;
            done_q  <= 1'b0;
            inf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            done_q  <= done_d;
            inf_q   <= inf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; op_q still names the command that just completed while in ST_WAIT.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        op_d    = op_q;
        done_d  = 1'b0;
        inf_d   = inf_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    m_d     = i_m;
                    idx_d   = IDX_W'(width_of(i_mode) - WIDTH_W'(1));
                    cnt_d   = '0;
                    inf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bit_c) begin
                    op_d    = OP_LOAD;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else begin
                    inf_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (i_op_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_op_done) begin
                    if (op_q == OP_DBL && bit_c) begin
                        op_d    = OP_ADD;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end else if (idx_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        op_d    = OP_DBL;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy     = busy_q;
    assign o_op_valid = valid_q;
    assign o_op       = op_q;
    assign o_done     = done_q;
    assign o_inf      = inf_q;
    assign o_op_cnt   = cnt_q;

endmodule

// File: tb/tb_ecc_smul_ctrl.sv
// Bench for ecc_smul_ctrl: directed jobs, a point-unit responder and a per-cycle checker against a command-list model.
module tb_ecc_smul_ctrl;

    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] DBL  = 2'b10;
    localparam logic [1:0] ADD  = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [1:0]   i_mode;
    logic [255:0] i_m;
    logic         o_busy;
    logic         o_op_valid;
    logic [1:0]   o_op;
    logic         i_op_ready;
    logic         i_op_done;
    logic         o_done;
    logic         o_inf;
    logic [9:0]   o_op_cnt;

    ecc_smul_ctrl #(.MAX_BITS(256)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_m(i_m),
        .o_busy(o_busy), .o_op_valid(o_op_valid), .o_op(o_op),
        .i_op_ready(i_op_ready), .i_op_done(i_op_done),
        .o_done(o_done), .o_inf(o_inf), .o_op_cnt(o_op_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Model of the current job: the full command list plus timing landmarks.
    logic [1:0] exp_q[$];
    logic       exp_inf;
    int         exp_cnt;
    int         exp_first;
    int         exp_done_cyc;

    int  stall_left = 0;
    bit  stall_req  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_job(input logic [1:0] mode, input logic [255:0] m);
        int w;
        int pos;
        w   = 32 << mode;
        pos = -1;
        exp_q.delete();
        for (int i = w - 1; i >= 0; i--) begin
            if (m[i]) begin
                pos = i;
                break;
            end
        end
        if (pos < 0) begin
            exp_inf      = 1'b1;
            exp_first    = -1;
            exp_done_cyc = w + 1;
        end else begin
            exp_inf      = 1'b0;
            exp_first    = 2 + (w - 1 - pos);
            exp_done_cyc = -1;
            exp_q.push_back(LOAD);
            for (int i = pos - 1; i >= 0; i--) begin
                exp_q.push_back(DBL);
                if (m[i]) exp_q.push_back(ADD);
            end
        end
        exp_cnt = exp_q.size();
    endtask

    // Point-unit responder: done two cycles after acceptance, optional 5-cycle stall on a DBL.
    initial begin
        int dcnt;
        dcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            i_op_done = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) i_op_done = 1'b1;
            end
            if (stall_req && o_op_valid && o_op == DBL) begin
                stall_left = 5;
                stall_req  = 1'b0;
            end
            if (stall_left > 0) begin
                i_op_ready = 1'b0;
                stall_left--;
            end else begin
                i_op_ready = 1'b1;
            end
            if (o_op_valid && i_op_ready) dcnt = 2;
        end
    end

    // Per-cycle checker against the model.
    initial begin
        int   cyc, start_cyc, n_acc;
        bit   exp_busy, rst_seen, prev_stall, outstanding, expect_next, first_seen;
        logic inf_now;
        logic [1:0] prev_op, want;
        cyc = 0; start_cyc = 0; n_acc = 0;
        exp_busy = 0; rst_seen = 0; prev_stall = 0; outstanding = 0; expect_next = 0; first_seen = 0;
        inf_now = 1'b0; prev_op = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rst_seen = 1; exp_busy = 0; prev_stall = 0; outstanding = 0; expect_next = 0;
                n_acc = 0; inf_now = 1'b0;
                exp_q.delete();
                continue;
            end
            if (rst_seen) begin
                rst_seen = 0;
                check("rst_busy",  32'(o_busy), 0);
                check("rst_valid", 32'(o_op_valid), 0);
                check("rst_op",    32'(o_op), 0);
                check("rst_done",  32'(o_done), 0);
                check("rst_inf",   32'(o_inf), 0);
                check("rst_cnt",   32'(o_op_cnt), 0);
            end
            check("busy", 32'(o_busy), 32'(exp_busy));
            check("op_cnt", 32'(o_op_cnt), 32'(n_acc));
            if (o_done) inf_now = exp_inf;
            check("inf", 32'(o_inf), 32'(inf_now));
            if (o_op_valid && !exp_busy) check("valid_outside_job", 32'(o_op_valid), 0);
            if (prev_stall) begin
                check("stall_valid", 32'(o_op_valid), 1);
                check("stall_op", 32'(o_op), 32'(prev_op));
            end
            if (expect_next) begin
                check("no_gap_after_done", 32'(o_op_valid | o_done), 1);
                expect_next = 0;
            end
            if (o_op_valid && exp_busy && !first_seen) begin
                first_seen = 1;
                check("first_load_cycle", 32'(cyc - start_cyc), 32'(exp_first));
            end
            if (o_op_valid && i_op_ready && exp_busy) begin
                if (exp_q.size() == 0) begin
                    check("extra_command", 32'(o_op), 0);
                end else begin
                    want = exp_q.pop_front();
                    check("command", 32'(o_op), 32'(want));
                end
                n_acc++;
                outstanding = 1;
            end
            if (i_op_done && outstanding) begin
                outstanding = 0;
                expect_next = 1;
            end
            prev_stall = o_op_valid && !i_op_ready;
            prev_op    = o_op;
            if (o_done) begin
                check("done_in_job", 32'(exp_busy), 1);
                check("done_queue_empty", 32'(exp_q.size()), 0);
                check("done_cnt", 32'(o_op_cnt), 32'(exp_cnt));
                if (exp_done_cyc >= 0)
                    check("done_cycle", 32'(cyc - start_cyc), 32'(exp_done_cyc));
                exp_busy = 0;
            end else if (i_start && !exp_busy) begin
                exp_busy   = 1;
                start_cyc  = cyc;
                n_acc      = 0;
                inf_now    = 1'b0;
                first_seen = 0;
            end
        end
    end

    task automatic pulse_start(input logic [1:0] mode, input logic [255:0] m, input bit build_model);
        @(posedge clk);
        #2;
        i_mode  = mode;
        i_m     = m;
        i_start = 1'b1;
        if (build_model) model_job(mode, m);
        @(posedge clk);
        #2;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 1);
    endtask

    task automatic after_job(input string name, input int cnt, input logic inf);
        @(negedge clk);
        check({name, "_cnt"},  32'(o_op_cnt), 32'(cnt));
        check({name, "_inf"},  32'(o_inf), 32'(inf));
        check({name, "_busy"}, 32'(o_busy), 0);
        check({name, "_done_pulse"}, 32'(o_done), 0);
    endtask

    initial begin
        logic [1:0]   pin_seq[6];
        logic [255:0] ones;
        bit           got_valid;
        rst = 1'b1; i_start = 1'b0; i_mode = 2'b00; i_m = '0;
        i_op_ready = 1'b1; i_op_done = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(o_busy), 0);
        check("reset_valid", 32'(o_op_valid), 0);
        check("reset_op", 32'(o_op), 0);
        check("reset_cnt", 32'(o_op_cnt), 0);

        pin_seq = '{LOAD, DBL, DBL, ADD, DBL, ADD};
        model_job(2'b00, 256'hB);
        check("model_b_len", 32'(exp_q.size()), 6);
        for (int i = 0; i < 6; i++) check("model_b_seq", 32'(exp_q[i]), 32'(pin_seq[i]));
        check("model_b_first", 32'(exp_first), 30);
        model_job(2'b00, 256'h0);
        check("model_zero_done", 32'(exp_done_cyc), 33);
        ones = '1;
        model_job(2'b11, ones);
        check("model_ones_len", 32'(exp_cnt), 511);

        pulse_start(2'b00, 256'hB, 1);
        wait_done("b");
        after_job("b", 6, 1'b0);

        pulse_start(2'b00, 256'h0, 1);
        wait_done("zero");
        after_job("zero", 0, 1'b1);

        pulse_start(2'b00, 256'hFFFF_FFFF_0000_0001, 1);
        wait_done("upper");
        after_job("upper", 1, 1'b0);

        pulse_start(2'b11, ones, 1);
        wait_done("ones");
        after_job("ones", 511, 1'b0);

        stall_req = 1'b1;
        pulse_start(2'b00, 256'hB, 1);
        repeat (10) @(posedge clk);
        pulse_start(2'b11, 256'h0, 0);
        wait_done("stall");
        after_job("stall", 6, 1'b0);
        check("stall_used", 32'(stall_req), 0);

        pulse_start(2'b01, 256'h8000_0000_0000_0003, 1);
        got_valid = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_op_valid) begin
                got_valid = 1;
                break;
            end
        end
        check("rst_job_valid_seen", 32'(got_valid), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("after_rst_idle_valid", 32'(o_op_valid), 0);
        check("after_rst_idle_busy", 32'(o_busy), 0);

        pulse_start(2'b00, 256'h1, 1);
        wait_done("one");
        after_job("one", 1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ecc_smul_ctrl.md
# ecc_smul_ctrl

Sequencer for elliptic-curve scalar multiplication. It scans the scalar `m` MSB-first using left-to-right double-and-add. It issues LOAD / DBL / ADD commands to the shared point-arithmetic unit over a valid/ready command channel and a done-pulse completion channel. It sits between the Wrapper's deserialised input registers and the point unit, and reports completion to the output serialiser.

## Interface
Parameters:
- `MAX_BITS`, default 256: widest supported operand; matches the `ECCDefine.vh` value.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_start` input 1: one-cycle start request.
- `i_mode` input 2: operand width. 00 = 32, 01 = 64, 10 = 128, 11 = 256.
- `i_m` input MAX_BITS: scalar. Bits at or above the selected width are ignored.
- `o_busy` output 1: high from the cycle after start acceptance through the DONE cycle.
- `o_op_valid` output 1: command valid.
- `o_op` output 2: command. 01 = LOAD (R=P), 10 = DBL (R=2R), 11 = ADD (R=R+P). 00 is never issued.
- `i_op_ready` input 1: point unit accepts the command this cycle.
- `i_op_done` input 1: one-cycle pulse; the outstanding command has finished.
- `o_done` output 1: one-cycle completion pulse.
- `o_inf` output 1: result is the point at infinity (scalar is zero). Valid while `o_done`=1; held until the next start.
- `o_op_cnt` output 10: number of commands issued in the current or last job.

## Operation
- States: IDLE, SCAN, ISSUE, WAIT, DONE.
- IDLE:
  - On `i_start`=1, latch `i_m` and `i_mode`.
  - Set W = 32 << `i_mode` and idx = W-1.
  - Clear `o_op_cnt` and `o_inf`, then go to SCAN.
- SCAN:
  - Tests one bit per cycle: m[idx].
  - If the bit is 1, set op = LOAD and go to ISSUE.
  - If the bit is 0 and idx>0, decrement idx.
  - If the bit is 0 and idx=0, set `o_inf`=1 and go to DONE. No commands are issued.
- ISSUE:
  - Drive `o_op_valid`=1 with `o_op`; both stay stable until `i_op_ready`=1.
  - On acceptance, increment `o_op_cnt` and go to WAIT.
- WAIT:
  - Wait for `i_op_done`, then choose the next step from the command that just completed:
  - After LOAD or ADD: if idx=0, go to DONE. Otherwise decrement idx and issue DBL.
  - After DBL: if m[idx]=1, issue ADD (idx unchanged). Else if idx=0, go to DONE. Else decrement idx and issue DBL.
- DONE: assert `o_done` for one cycle, then return to IDLE.
- Command count for bit-length L and popcount H (H≥1): 1 LOAD + (L-1) DBL + (H-1) ADD.
- idx is an 8-bit down-counter; W-1 ≤ 255.

## Timing
- Reset values:
  - `o_busy`, `o_op_valid`, `o_done`, `o_inf` = 0.
  - `o_op` = 00, `o_op_cnt` = 0.
  - State = IDLE.
- Reset asserted mid-job: everything returns to reset values on the next edge. An in-flight `i_op_done` after reset is ignored.
- Start sampled in cycle 0:
  - SCAN tests bit W-1 in cycle 1.
  - The first LOAD is valid in cycle 1+z+1, where z is the number of leading zeros.
- `i_op_done` sampled in cycle t: the next command is valid in t+1 (or `o_done` in t+1). No idle cycles between commands.
- `i_start` while `o_busy`: ignored.
- `i_op_done` outside WAIT: ignored.
- `i_op_done` in the same cycle as acceptance: not legal. Done must arrive ≥1 cycle after acceptance, and the controller only samples done in WAIT.
- `i_op_ready` and `i_op_done` are never required to be high together.
- All outputs are registered.

## Structure
- Shared package, in `ECCDefine.vh`:
  - `MAX_BITS`.
  - OP_LOAD / OP_DBL / OP_ADD encodings.
  - MODE_32..MODE_256 encodings.
  - Width-decode constant (32 << mode).
- Single module, no sub-module. The width decode is a shift and the scalar bit select is a mux on the latched register.

## Test plan
- mode=00, m=0x0000000B, ready always 1, done 2 cycles after accept:
  - Command sequence is LOAD, DBL, DBL, ADD, DBL, ADD.
  - `o_op_cnt`=6, `o_inf`=0, one `o_done` pulse.
- mode=00, m=0: 32 SCAN cycles, `o_done` at cycle 33 after start, `o_inf`=1, `o_op_valid` never high, `o_op_cnt`=0.
- mode=00, m=0xFFFFFFFF_00000001 (upper bits ignored): a single LOAD, then `o_done`; `o_op_cnt`=1.
- mode=11, m all ones: 511 commands alternating DBL/ADD after the LOAD; `o_op_cnt`=511.
- `i_op_ready` held low 5 cycles during a DBL:
  - `o_op_valid` and `o_op` stay stable for those cycles.
  - A second `i_start` during the job is ignored, and the job result is unchanged.
- `rst` pulsed during WAIT of a mode=01 job: outputs at reset values next cycle. A subsequent start with m=1 completes normally (`o_op_cnt`=1).
